mux2: RTL and testbench
=======================

MUX2 -- requirements
Module: mux2

Interface
REQ-001 Parameter DATA_PACKET_SIZE, default 4: width in bits of data_1, data_2 and out; legal range 1..1024.
REQ-002 Parameter REGISTERED_OUTPUT, default 0: 0 = combinational select path; 1 = one-cycle registered select path.
REQ-003 clk  input  1  sole clock; all sequential logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 data_1  input  DATA_PACKET_SIZE  operand routed to out when select = 0.
REQ-006 data_2  input  DATA_PACKET_SIZE  operand routed to out when select = 1.
REQ-007 select  input  1  path select.
REQ-008 out  output  DATA_PACKET_SIZE  selected operand.

Function
REQ-009 REGISTERED_OUTPUT=0, reset low: out SHALL equal data_1 when select = 0 and data_2 when select = 1, combinationally, zero cycles latency, with no dependence on clk.
REQ-010 REGISTERED_OUTPUT=0, reset high: out SHALL be forced to all-zeros for as long as reset is high, independent of select and data.
REQ-011 REGISTERED_OUTPUT=1: out SHALL be a register loaded on each rising clk edge with the REQ-009 selection of the values sampled at that edge, giving one cycle latency.
REQ-012 REGISTERED_OUTPUT=1: a rising edge with reset high SHALL load all-zeros; reset has priority over the data path.
REQ-013 select = 1'bx, simulation only: out SHALL be all-X; do not pick either operand and do not do a bitwise merge.
REQ-014 select = 1'bz, simulation only: out SHALL be all-Z.
REQ-015 Synthesis SHALL treat REQ-013 and REQ-014 as don't-care; no tristate or extra logic is inferred for them.
REQ-016 X or Z bits on the selected operand SHALL pass through to out unchanged.
REQ-017 X or Z bits on the unselected operand SHALL NOT affect out.
REQ-018 Operand boundary values 0 and 2**DATA_PACKET_SIZE-1 SHALL pass unmodified; no arithmetic, truncation or sign extension is performed.
REQ-019 A select change and an operand change in the same timestep SHALL resolve to the new select and new operands:
- combinational mode: within the same delta settle;
- registered mode: at the next edge.

Reset
REQ-020 Reset is synchronous and active-high.
REQ-021 No asynchronous reset path SHALL exist.
REQ-022 Registered mode: out SHALL hold all-zeros from the first edge with reset high until the first edge after reset deasserts.
REQ-023 Combinational mode: out SHALL follow REQ-010 while reset is high and SHALL resume REQ-009 immediately when reset deasserts.
REQ-024 Before the first clock edge, registered out SHALL be X in simulation; reset SHALL be applied for at least one edge before out is checked.

Verification
REQ-025 Exhaustive sweep, default parameters, reset=0, select=0: all 256 pairs of data_1 and data_2 over 0..15 -> out == data_1 for every pair (e.g. data_1=9, data_2=3 -> out=9).
REQ-026 Repeat the sweep with select=1 -> out == data_2 for every pair (e.g. data_1=9, data_2=3 -> out=3).
REQ-027 select=1'bz with any data -> out === 4'bzzzz; select=1'bx with any data -> out === 4'bxxxx.
REQ-028 Combinational mode, reset=1, select=1, data_2=15 -> out=0; deassert reset -> out=15 in the same timestep.
REQ-029 REGISTERED_OUTPUT=1:
- data_1=5, select=0 applied before edge N -> out=5 after edge N, not earlier;
- reset high at edge N+1 -> out=0.
REQ-030 Unselected operand driven to X (select=0, data_2=4'bxxxx, data_1=10) -> out=10.
REQ-031 Every check SHALL use case equality (===) so that X and Z mismatches are detected.

Source files
------------

// File: rtl/mux2.sv
// Two-input operand select with an optional one-cycle output register.
// Reset is synchronous and forces the routed value to zero in both modes.
module mux2 #(
    parameter int unsigned DATA_PACKET_SIZE  = 4,
    parameter bit          REGISTERED_OUTPUT = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_PACKET_SIZE-1:0] data_1,
    input  logic [DATA_PACKET_SIZE-1:0] data_2,
    input  logic                        select,
    output logic [DATA_PACKET_SIZE-1:0] out
);

    logic [DATA_PACKET_SIZE-1:0] sel_val;
    logic [DATA_PACKET_SIZE-1:0] out_d;
    logic [DATA_PACKET_SIZE-1:0] out_q;

    always_comb begin
        sel_val = data_1;
        case (select)
            1'b0:    sel_val = data_1;
            1'b1:    sel_val = data_2;
            // Unknown select replicates itself: all-X for X, all-Z for Z; unreachable in hardware.
            default: sel_val = {DATA_PACKET_SIZE{select}};
        endcase
    end

    always_comb begin
        out_d = reset ? '0 : sel_val;
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign out = REGISTERED_OUTPUT ? out_q : out_d;

endmodule

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: one combinational and one registered instance share stimulus.
module tb_mux2;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_1;
    logic [W-1:0] data_2;
    logic         select;
    logic [W-1:0] out_c;
    logic [W-1:0] out_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux2 #(.DATA_PACKET_SIZE(W), .REGISTERED_OUTPUT(1'b0)) dut_c (
        .clk    (clk),
        .reset  (reset),
        .data_1 (data_1),
        .data_2 (data_2),
        .select (select),
        .out    (out_c)
    );

    mux2 #(.DATA_PACKET_SIZE(W), .REGISTERED_OUTPUT(1'b1)) dut_r (
        .clk    (clk),
        .reset  (reset),
        .data_1 (data_1),
        .data_2 (data_2),
        .select (select),
        .out    (out_r)
    );

    // Reference: reset wins, otherwise pick by select.
    function automatic logic [W-1:0] model(input logic rst, input logic sel,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (rst) return '0;
        return sel ? b : a;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b1;
        select = 1'b1;
        data_1 = 4'd6;
        data_2 = 4'd9;
        @(posedge clk);
        #1;
        total++;
        if (out_c !== 4'd0) begin
            bad++;
            $display("FAIL reset_comb: got %b want 0000", out_c);
        end
        total++;
        if (out_r !== 4'd0) begin
            bad++;
            $display("FAIL reset_reg: got %b want 0000", out_r);
        end
    endtask

    task automatic test_sweep(input logic sel);
        logic [W-1:0] exp_v;
        reset  = 1'b0;
        select = sel;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                data_1 = a[W-1:0];
                data_2 = b[W-1:0];
                #1;
                exp_v = sel ? b[W-1:0] : a[W-1:0];
                total++;
                if (out_c !== exp_v) begin
                    bad++;
                    $display("FAIL sweep_sel%0b d1=%0d d2=%0d: got %b want %b",
                             sel, a, b, out_c, exp_v);
                end
            end
        end
    endtask

    task automatic test_xz_select();
        logic probe;
        probe = 1'bz;
        // Only meaningful on a four-state simulator.
        if ($isunknown(probe)) begin
            reset  = 1'b0;
            data_1 = 4'd9;
            data_2 = 4'd3;
            select = 1'bz;
            #1;
            total++;
            if (out_c !== 4'bzzzz) begin
                bad++;
                $display("FAIL sel_z: got %b want zzzz", out_c);
            end
            select = 1'bx;
            #1;
            total++;
            if (out_c !== 4'bxxxx) begin
                bad++;
                $display("FAIL sel_x: got %b want xxxx", out_c);
            end
            select = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset_release();
        reset  = 1'b1;
        select = 1'b1;
        data_1 = 4'd2;
        data_2 = 4'd15;
        #1;
        total++;
        if (out_c !== 4'd0) begin
            bad++;
            $display("FAIL comb_reset_hold: got %b want 0000", out_c);
        end
        reset = 1'b0;
        #1;
        total++;
        if (out_c !== 4'd15) begin
            bad++;
            $display("FAIL comb_reset_release: got %b want 1111", out_c);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        reset  = 1'b0;
        select = 1'b0;
        data_1 = 4'd0;
        data_2 = 4'd12;
        @(posedge clk);
        @(negedge clk);
        data_1 = 4'd5;
        #1;
        total++;
        if (out_r !== 4'd0) begin
            bad++;
            $display("FAIL reg_early: got %b want 0000", out_r);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_r !== 4'd5) begin
            bad++;
            $display("FAIL reg_latency: got %b want 0101", out_r);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (out_r !== 4'd5) begin
            bad++;
            $display("FAIL reg_reset_sync: got %b want 0101", out_r);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_r !== 4'd0) begin
            bad++;
            $display("FAIL reg_reset: got %b want 0000", out_r);
        end
        @(negedge clk);
        reset  = 1'b0;
        select = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_r !== 4'd12) begin
            bad++;
            $display("FAIL reg_after_reset: got %b want 1100", out_r);
        end
    endtask

    task automatic test_unselected_x();
        @(negedge clk);
        reset  = 1'b0;
        select = 1'b0;
        data_1 = 4'd10;
        data_2 = 4'bxxxx;
        #1;
        total++;
        if (out_c !== 4'd10) begin
            bad++;
            $display("FAIL unsel_x_comb: got %b want 1010", out_c);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_r !== 4'd10) begin
            bad++;
            $display("FAIL unsel_x_reg: got %b want 1010", out_r);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_c;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            reset  = ($urandom_range(0, 7) == 0);
            select = 1'($urandom_range(0, 1));
            data_1 = W'($urandom);
            data_2 = W'($urandom);
            #1;
            exp_c = model(reset, select, data_1, data_2);
            total++;
            if (out_c !== exp_c) begin
                bad++;
                $display("FAIL rand_comb i=%0d: got %b want %b", i, out_c, exp_c);
            end
            if (i > 0) begin
                total++;
                if (out_r !== exp_r) begin
                    bad++;
                    $display("FAIL rand_reg_hold i=%0d: got %b want %b", i, out_r, exp_r);
                end
            end
            @(posedge clk);
            exp_r = model(reset, select, data_1, data_2);
            #1;
            total++;
            if (out_r !== exp_r) begin
                bad++;
                $display("FAIL rand_reg i=%0d: got %b want %b", i, out_r, exp_r);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        select = 1'b0;
        data_1 = '0;
        data_2 = '0;
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_xz_select();
        test_reset_release();
        test_registered();
        test_unselected_x();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
